// File: rtl/memory_board.sv
// Memory-game board controller: shared cursor, two-flip turns, pair compare,
// mismatch hold window, two-player scoring and end-of-game detection.
module memory_board #(
    parameter int unsigned N_TILES     = 16,
    parameter int unsigned LABEL_W     = 4,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 move,
    input  logic                                 select,
    input  logic [N_TILES*LABEL_W-1:0]           labels_in,
    output logic [2*N_TILES-1:0]                 tile_view,
    output logic [$clog2(N_TILES)-1:0]           cursor,
    output logic                                 player,
    output logic [$clog2(N_TILES/2+1)-1:0]       score0,
    output logic [$clog2(N_TILES/2+1)-1:0]       score1,
    output logic                                 match_pulse,
    output logic                                 mismatch_pulse,
    output logic                                 done
);

    localparam int unsigned IDX_W   = $clog2(N_TILES);
    localparam int unsigned SCORE_W = $clog2(N_TILES/2+1);
    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES+1);

    localparam logic [2:0] S_FIRST   = 3'd0;
    localparam logic [2:0] S_SECOND  = 3'd1;
    localparam logic [2:0] S_COMPARE = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [1:0] T_HIDDEN  = 2'b00;
    localparam logic [1:0] T_FLIPPED = 2'b01;
    localparam logic [1:0] T_MATCHED = 2'b10;

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   cursor_q, cursor_d;
    logic [IDX_W-1:0]   a_q, a_d;
    logic [IDX_W-1:0]   b_q, b_d;
    logic [1:0]         tile_q [N_TILES];
    logic [1:0]         tile_d [N_TILES];
    logic               player_q, player_d;
    logic [SCORE_W-1:0] score0_q, score0_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] pairs_q, pairs_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               match_q, match_d;
    logic               mismatch_q, mismatch_d;
    logic               done_q, done_d;

    logic [LABEL_W-1:0] label_arr [N_TILES];
    logic [IDX_W-1:0]   cursor_next;
    logic               last_pair;

    // Unpack labels and pack tile codes for the outputs
    for (genvar i = 0; i < int'(N_TILES); i++) begin : g_tiles
        assign label_arr[i]         = labels_in[i*LABEL_W +: LABEL_W];
        assign tile_view[2*i +: 2]  = tile_q[i];
    end

    assign cursor_next = (cursor_q == IDX_W'(N_TILES-1)) ? '0 : cursor_q + IDX_W'(1);
    assign last_pair   = (pairs_q == SCORE_W'(N_TILES/2-1));

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        a_d        = a_q;
        b_d        = b_q;
        tile_d     = tile_q;
        player_d   = player_q;
        score0_d   = score0_q;
        score1_d   = score1_q;
        pairs_d    = pairs_q;
        hold_d     = hold_q;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        done_d     = done_q;

        // Select below uses cursor_q, so a simultaneous move acts after it
        if (move && (state_q != S_DONE)) begin
            cursor_d = cursor_next;
        end

        case (state_q)
            S_FIRST: begin
                if (select && (tile_q[cursor_q] == T_HIDDEN)) begin
                    tile_d[cursor_q] = T_FLIPPED;
                    a_d              = cursor_q;
                    state_d          = S_SECOND;
                end
            end
            S_SECOND: begin
                if (select && (tile_q[cursor_q] == T_HIDDEN)) begin
                    tile_d[cursor_q] = T_FLIPPED;
                    b_d              = cursor_q;
                    state_d          = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (label_arr[a_q] == label_arr[b_q]) begin
                    tile_d[a_q] = T_MATCHED;
                    tile_d[b_q] = T_MATCHED;
                    if (player_q) begin
                        score1_d = score1_q + SCORE_W'(1);
                    end else begin
                        score0_d = score0_q + SCORE_W'(1);
                    end
                    match_d = 1'b1;
                    pairs_d = pairs_q + SCORE_W'(1);
                    if (last_pair) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FIRST;
                    end
                end else begin
                    mismatch_d = 1'b1;
                    hold_d     = HOLD_W'(HOLD_CYCLES);
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    hold_d      = '0;
                    tile_d[a_q] = T_HIDDEN;
                    tile_d[b_q] = T_HIDDEN;
                    player_d    = ~player_q;
                    state_d     = S_FIRST;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_FIRST;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FIRST;
            cursor_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            for (int i = 0; i < int'(N_TILES); i++) begin
                tile_q[i] <= T_HIDDEN;
            end
            player_q   <= 1'b0;
            score0_q   <= '0;
            score1_q   <= '0;
            pairs_q    <= '0;
            hold_q     <= '0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            a_q        <= a_d;
            b_q        <= b_d;
            tile_q     <= tile_d;
            player_q   <= player_d;
            score0_q   <= score0_d;
            score1_q   <= score1_d;
            pairs_q    <= pairs_d;
            hold_q     <= hold_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
        end
    end

    assign cursor         = cursor_q;
    assign player         = player_q;
    assign score0         = score0_q;
    assign score1         = score1_q;
    assign match_pulse    = match_q;
    assign mismatch_pulse = mismatch_q;
    assign done           = done_q;

endmodule

// File: tb/tb_memory_board.sv
// Directed bench: a 16-tile board for cursor/match/mismatch/reset behaviour
// and a 4-tile board played to completion; both share the button inputs.
module tb_memory_board;

    logic clk;
    logic rst;
    logic move;
    logic select;

    // tile0..15 labels: 3,3,5,5,0,0,1,1,2,2,4,4,6,6,7,7
    logic [63:0] labels16;
    logic [31:0] tv16;
    logic [3:0]  cur16;
    logic        pl16;
    logic [3:0]  s0_16, s1_16;
    logic        mp16, mmp16, done16;

    // tile0..3 labels: 1,2,1,2
    logic [15:0] labels4;
    logic [7:0]  tv4;
    logic [1:0]  cur4;
    logic        pl4;
    logic [1:0]  s0_4, s1_4;
    logic        mp4, mmp4, done4;

    int n_checks;
    int n_fail;

    memory_board #(.N_TILES(16), .LABEL_W(4), .HOLD_CYCLES(4)) dut16 (
        .clk(clk), .rst(rst), .move(move), .select(select),
        .labels_in(labels16), .tile_view(tv16), .cursor(cur16),
        .player(pl16), .score0(s0_16), .score1(s1_16),
        .match_pulse(mp16), .mismatch_pulse(mmp16), .done(done16)
    );

    memory_board #(.N_TILES(4), .LABEL_W(4), .HOLD_CYCLES(2)) dut4 (
        .clk(clk), .rst(rst), .move(move), .select(select),
        .labels_in(labels4), .tile_view(tv4), .cursor(cur4),
        .player(pl4), .score0(s0_4), .score1(s1_4),
        .match_pulse(mp4), .mismatch_pulse(mmp4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with post-edge values visible
    task automatic step(input logic s, input logic m);
        select = s;
        move   = m;
        @(negedge clk);
        select = 1'b0;
        move   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        labels16 = 64'h7766_4422_1100_5533;
        labels4  = 16'h2121;
        rst      = 1'b0;
        move     = 1'b0;
        select   = 1'b0;
        do_reset();

        // Reset state
        check("rst_tiles", 64'(tv16), 64'h0);
        check("rst_cursor", 64'(cur16), 64'd0);
        check("rst_player", 64'(pl16), 64'd0);
        check("rst_score0", 64'(s0_16), 64'd0);
        check("rst_score1", 64'(s1_16), 64'd0);
        check("rst_done", 64'(done16), 64'd0);
        check("rst_pulses", 64'({mp16, mmp16}), 64'd0);

        // Cursor wrap: 17 moves -> 1, 15 more -> 0
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1);
        check("cursor_17", 64'(cur16), 64'd1);
        check("cursor_tiles", 64'(tv16), 64'h0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        check("cursor_wrap", 64'(cur16), 64'd0);

        // Match on tiles 0,1 with an illegal reselect of tile A
        step(1'b1, 1'b0);
        check("first_flip", 64'(tv16), 64'h1);
        step(1'b1, 1'b0);
        check("reselect_a", 64'(tv16), 64'h1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("second_flip", 64'(tv16), 64'h5);
        check("no_early_match", 64'(mp16), 64'd0);
        step(1'b0, 1'b0);
        check("match_tiles", 64'(tv16), 64'hA);
        check("match_score0", 64'(s0_16), 64'd1);
        check("match_pulse", 64'(mp16), 64'd1);
        check("match_player", 64'(pl16), 64'd0);
        step(1'b0, 1'b0);
        check("match_pulse_end", 64'(mp16), 64'd0);

        // Select on a matched tile in FIRST is ignored
        step(1'b1, 1'b0);
        check("sel_matched", 64'(tv16), 64'hA);

        // Mismatch: tile2 (5) vs tile4 (0); select+move acts on pre-move cursor
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("flip_t2", 64'(tv16), 64'h1A);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("sel_move_tiles", 64'(tv16), 64'h11A);
        check("sel_move_cursor", 64'(cur16), 64'd5);
        step(1'b0, 1'b0);
        check("mismatch_pulse", 64'(mmp16), 64'd1);
        check("mismatch_nomatch", 64'(mp16), 64'd0);
        check("hold1_tiles", 64'(tv16), 64'h11A);
        step(1'b1, 1'b0);
        check("hold_sel_ignored", 64'(tv16), 64'h11A);
        check("mismatch_pulse_end", 64'(mmp16), 64'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("hold4_tiles", 64'(tv16), 64'h11A);
        check("hold4_player", 64'(pl16), 64'd0);
        step(1'b0, 1'b0);
        check("hidden_again", 64'(tv16), 64'hA);
        check("player_toggle", 64'(pl16), 64'd1);
        check("score_kept0", 64'(s0_16), 64'd1);
        check("score_kept1", 64'(s1_16), 64'd0);
        step(1'b1, 1'b0);
        check("next_select", 64'(tv16), 64'h40A);

        // Second mismatch (tile5 vs tile6), then reset during HOLD
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("flip_t6", 64'(tv16), 64'h140A);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_tiles", 64'(tv16), 64'h0);
        check("midrst_player", 64'(pl16), 64'd0);
        check("midrst_score0", 64'(s0_16), 64'd0);
        check("midrst_cursor", 64'(cur16), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0);
        check("midrst_flip", 64'(tv16), 64'h1);

        // Full 4-tile game with one mismatch
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("g4_two_flipped", 64'(tv4), 64'h05);
        step(1'b0, 1'b0);
        check("g4_mismatch", 64'(mmp4), 64'd1);
        step(1'b0, 1'b0);
        check("g4_hold", 64'(tv4), 64'h05);
        step(1'b0, 1'b0);
        check("g4_hidden", 64'(tv4), 64'h00);
        check("g4_player1", 64'(pl4), 64'd1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("g4_match1_tiles", 64'(tv4), 64'h88);
        check("g4_match1_score1", 64'(s1_4), 64'd1);
        check("g4_match1_done", 64'(done4), 64'd0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("g4_last_flip", 64'(tv4), 64'h99);
        step(1'b0, 1'b0);
        check("g4_final_tiles", 64'(tv4), 64'hAA);
        check("g4_done", 64'(done4), 64'd1);
        check("g4_final_pulse", 64'(mp4), 64'd1);
        check("g4_score_sum", 64'(s0_4) + 64'(s1_4), 64'd2);
        check("g4_score1", 64'(s1_4), 64'd2);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("g4_frozen_cursor", 64'(cur4), 64'd2);
        check("g4_frozen_tiles", 64'(tv4), 64'hAA);
        check("g4_frozen_done", 64'(done4), 64'd1);
        check("g4_frozen_player", 64'(pl4), 64'd1);
        check("g4_no_pulse", 64'({mp4, mmp4}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_board.md
# memory_board

Parametrised memory-game board controller: N_TILES tiles, each with a fixed label, a shared cursor, two-flip turns, pair comparison, a mismatch hold window, two-player turn and score tracking, and end-of-game detection. It is the successor to the single-tile cell and replaces per-tile state machines with one board-level FSM plus per-tile state registers. It sits between the debounced button inputs and the display or VGA renderer.

## Interface
- N_TILES, 16, number of tiles; even, at least 2
- LABEL_W, 4, label width in bits
- HOLD_CYCLES, 4, cycles a mismatched pair stays visible before being hidden; at least 1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- move  in  1  one-cycle pulse; advances the cursor
- select  in  1  one-cycle pulse; flips the tile under the cursor
- labels_in  in  N_TILES*LABEL_W  tile labels, tile i at [i*LABEL_W +: LABEL_W]; static during a game; each label value appears exactly twice
- tile_view  out  2*N_TILES  per-tile code: 00 hidden, 01 flipped, 10 matched; tile i at [2i +: 2]
- cursor  out  $clog2(N_TILES)  current cursor index
- player  out  1  player whose turn it is
- score0, score1  out  $clog2(N_TILES/2+1)  pairs won by each player
- match_pulse  out  1  one cycle high on a successful pair
- mismatch_pulse  out  1  one cycle high on a failed pair
- done  out  1  high once all tiles are matched

## Operation
- Reset values: all tiles hidden; cursor, player, score0, score1, match_pulse, mismatch_pulse, done all 0; FSM in FIRST.
- FSM states: FIRST, SECOND, COMPARE, HOLD, DONE.
- move, in any state except DONE: cursor becomes cursor+1, wrapping from N_TILES-1 to 0. In DONE, move is ignored.
- FIRST: select on a hidden tile sets that tile to flipped, records its index as A, and goes to SECOND. Select on a flipped or matched tile is ignored.
- SECOND: select on a hidden tile sets it to flipped, records its index as B, and goes to COMPARE. Select on tile A or on a matched tile is ignored.
- COMPARE, one cycle:
  - label[A]==label[B]: both tiles become matched, the current player's score increments, match_pulse fires, and player is unchanged. Go to DONE if this was the last hidden pair, otherwise go to FIRST.
  - Labels differ: mismatch_pulse fires, the hold counter loads HOLD_CYCLES, and the FSM goes to HOLD.
- HOLD: the counter decrements each cycle. On the cycle it reaches 0, tiles A and B return to hidden, player toggles, and the FSM goes to FIRST.
- Select is ignored in COMPARE, HOLD and DONE. It is not queued.
- When select and move arrive in the same cycle, select acts on the pre-move cursor, then the cursor advances.
- DONE: done=1; board, scores and player are frozen until rst.
- A matched-pair counter, width $clog2(N_TILES/2+1), drives end detection: DONE is entered when it reaches N_TILES/2.
- Score arithmetic does not saturate; it cannot overflow by construction.

## Timing
- All outputs are registered. Inputs are sampled on the rising clk edge.
- First select at edge t: the tile reads 01 after edge t.
- Second select at edge t2: the tile reads 01 after t2, and the FSM is in COMPARE during cycle t2+1.
- Match: after edge t2+1, both tiles read 10, the score is updated, and match_pulse is high for exactly that cycle.
- Mismatch: mismatch_pulse is high for the cycle after t2+1. The tiles read 01 through HOLD_CYCLES cycles of HOLD, then read 00 and player is toggled after edge t2+1+HOLD_CYCLES. The earliest next accepted select is at the following edge.
- done rises in the same cycle the final pair reads 10.
- rst assertion mid-game (any state, including HOLD) immediately forces the reset values. The first edge after release behaves as FIRST.

## Test plan
- Reset/cursor: release rst, send 17 move pulses with N_TILES=16 -> cursor=1, all tile_view=00, scores 0, done=0.
- Match: labels_in tile0=3, tile1=3; select@0, move, select@1 -> tiles 0,1 read 10, score0=1, player=0, one match_pulse.
- Mismatch hold: tile0=3, tile2=5, HOLD_CYCLES=4; flip 0 then 2 -> both read 01 for 4 HOLD cycles, then 00; player=1; score unchanged; one mismatch_pulse; a select during HOLD is ignored.
- Illegal selects: select an already flipped tile in SECOND, then a matched tile in FIRST -> FSM state and tile_view unchanged.
- Full game: N_TILES=4, labels 1,2,1,2; play to completion with one mismatch -> done=1 on the last match, scores sum to 2, later move/select pulses have no effect.
- Mid-game reset: assert rst during HOLD -> all tiles 00, player 0, scores 0, cursor 0; the next select flips the tile at cursor 0.
